// File: rtl/lm32_sdp_ram_pkg.sv
// lm32_sdp_ram_pkg: codebase-wide boolean constants.
// Imported by lm32_sdp_ram.
package lm32_sdp_ram_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/lm32_sdp_ram.sv
// lm32_sdp_ram: simple dual-port RAM (one write, one read port).
// Storage behind the LM32 caches and TLBs. Reads use a registered
// address, so data appears the cycle after the address is captured.
//
// Parameters:
//   data_width     bits per word
//   address_width  address bits, depth = 2**address_width
// Ports:
//   clk_i          clock, rising edge
//   rst_i          async active-high reset, clears read address reg
//   read_address   read word address
//   enable_read    capture read_address at the clock edge
//   write_address  write word address
//   enable_write   write port clock enable
//   write_enable   write strobe (write when both enables high)
//   write_data     data to write
//   read_data      mem[registered read address]
// Build option:
//   LM32_SDP_RAM_INIT_ZERO_EN  power-up contents all zero
import lm32_sdp_ram_pkg::*;

module lm32_sdp_ram #(
    parameter int data_width    = 32,
    parameter int address_width = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [address_width-1:0] read_address,
    input  logic                     enable_read,
    input  logic [address_width-1:0] write_address,
    input  logic                     enable_write,
    input  logic                     write_enable,
    input  logic [data_width-1:0]    write_data,
    output logic [data_width-1:0]    read_data
);

    localparam int depth = 1 << address_width;

`ifdef LM32_SDP_RAM_INIT_ZERO_EN
    logic [data_width-1:0] mem [0:depth-1] = '{default: '0};
`else
    logic [data_width-1:0] mem [0:depth-1];
`endif

    logic [address_width-1:0] ra_q;
    logic                     wr_go;

    assign wr_go = (enable_write == TRUE) &&
                   (write_enable == TRUE) &&
                   (rst_i == FALSE);

    // Memory has no reset; rst_i only gates writes.
    always_ff @(posedge clk_i) begin
        if (wr_go) begin
            mem[write_address] <= write_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ra_q <= '0;
        end else if (enable_read == TRUE) begin
            ra_q <= read_address;
        end
    end

    // Array read from the registered address: a write to mem[ra_q]
    // shows up right after its edge, giving write-first behaviour.
    assign read_data = mem[ra_q];

endmodule

// File: tb/tb_lm32_sdp_ram.sv
// tb_lm32_sdp_ram: directed self-checking bench for lm32_sdp_ram.
// Hand-computed expectations; one check task for all comparisons.
module tb_lm32_sdp_ram;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [9:0]  read_address;
    logic        enable_read;
    logic [9:0]  write_address;
    logic        enable_write;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int n_vec = 0;
    int n_err = 0;

    lm32_sdp_ram #(
        .data_width(32),
        .address_width(10)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .read_address(read_address),
        .enable_read(enable_read),
        .write_address(write_address),
        .enable_write(enable_write),
        .write_enable(write_enable),
        .write_data(write_data),
        .read_data(read_data)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        write_address = a;
        write_data    = d;
        enable_write  = 1'b1;
        write_enable  = 1'b1;
        tick();
        enable_write  = 1'b0;
        write_enable  = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a);
        read_address = a;
        enable_read  = 1'b1;
        tick();
        enable_read  = 1'b0;
    endtask

    initial begin
        logic [9:0] probe [6];
        probe = '{10'd0, 10'd3, 10'd100, 10'd511, 10'd600, 10'd1023};

        rst_i         = 1'b1;
        read_address  = '0;
        enable_read   = 1'b0;
        write_address = '0;
        enable_write  = 1'b0;
        write_enable  = 1'b0;
        write_data    = '0;
        tick();
        tick();
`ifdef LM32_SDP_RAM_INIT_ZERO_EN
        check("init_zero", read_data, 32'h0);
`endif
        rst_i = 1'b0;

        wr(10'd0, 32'hCAFE_0000);
        rd(10'd0);
        check("rd_a0", read_data, 32'hCAFE_0000);

        wr(10'd5, 32'h1234_5678);
        rd(10'd5);
        check("rd_a5", read_data, 32'h1234_5678);

        // async reset mid-cycle, no edge
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_async", read_data, 32'hCAFE_0000);
        // write attempted while in reset is dropped
        write_address = 10'd0;
        write_data    = 32'hDEAD_BEEF;
        enable_write  = 1'b1;
        write_enable  = 1'b1;
        tick();
        enable_write  = 1'b0;
        write_enable  = 1'b0;
        check("rst_nowr", read_data, 32'hCAFE_0000);
        rst_i = 1'b0;

        // enable_write low blocks write
        write_address = 10'd0;
        write_data    = 32'h1111_1111;
        enable_write  = 1'b0;
        write_enable  = 1'b1;
        tick();
        check("ew_low", read_data, 32'hCAFE_0000);
        // write_enable low blocks write
        enable_write  = 1'b1;
        write_enable  = 1'b0;
        tick();
        enable_write  = 1'b0;
        check("we_low", read_data, 32'hCAFE_0000);

        // enable_read low holds address
        rd(10'd5);
        read_address = 10'd0;
        tick();
        check("er_hold", read_data, 32'h1234_5678);
        // tracking a write to the held address
        wr(10'd5, 32'h0BAD_F00D);
        check("er_track", read_data, 32'h0BAD_F00D);

        // write hits the registered address
        wr(10'd7, 32'h0000_AAAA);
        rd(10'd7);
        check("wf_pre", read_data, 32'h0000_AAAA);
        wr(10'd7, 32'h0000_5555);
        check("wf_ra", read_data, 32'h0000_5555);

        // same-edge read and write of one address
        read_address  = 10'd9;
        enable_read   = 1'b1;
        write_address = 10'd9;
        write_data    = 32'h0000_9999;
        enable_write  = 1'b1;
        write_enable  = 1'b1;
        tick();
        enable_read   = 1'b0;
        enable_write  = 1'b0;
        write_enable  = 1'b0;
        check("wf_same", read_data, 32'h0000_9999);

        // boundary addresses
        wr(10'd1023, 32'hFFFF_0001);
        wr(10'd0, 32'h0000_FFFE);
        rd(10'd1023);
        check("bnd_hi", read_data, 32'hFFFF_0001);
        rd(10'd0);
        check("bnd_lo", read_data, 32'h0000_FFFE);

        // sentinels for the flush
        wr(10'd600, 32'h0000_0077);
        wr(10'd100, 32'h0000_0066);

        // flush upper half, descending
        for (int a = 1023; a >= 512; a--) begin
            wr(a[9:0], 32'h0);
        end
        rd(10'd5);
        #2;
        rst_i = 1'b1;
        #1;
        check("fl_rst", read_data, 32'h0000_FFFE);
        tick();
        rst_i = 1'b0;
        rd(10'd600);
        check("fl_600", read_data, 32'h0);
        rd(10'd100);
        check("fl_100", read_data, 32'h0000_0066);
        rd(10'd5);
        check("fl_5", read_data, 32'h0BAD_F00D);

        // finish the flush
        for (int a = 511; a >= 0; a--) begin
            wr(a[9:0], 32'h0);
        end
        for (int i = 0; i < 6; i++) begin
            rd(probe[i]);
            check($sformatf("fl_z%0d", probe[i]), read_data, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
